// File: rtl/interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
//
// Programmable interval store and one-second countdown timer for the
// traffic-light controller. Three interval registers (base green, extended
// green/walk, yellow) hold durations in seconds. A start loads the selected
// interval and counts it down at one step per CLK_DIV clocks. Reaching zero
// produces a single-cycle expired pulse and the timer returns to idle.
//
// Parameters
//   CLK_DIV   clock cycles per one-second tick (>= 2)
//   VAL_W     width of the interval values in seconds
//   DEF_BASE  reset/default value of the base interval     (address 2'b00)
//   DEF_EXT   reset/default value of the extended interval (address 2'b01)
//   DEF_YEL   reset/default value of the yellow interval   (address 2'b10)
//
// Ports
//   clk               system clock, rising edge
//   sys_reset         synchronous active-high reset
//   prg_sync_in       one-shot program strobe (already synchronized)
//   time_param_sel    register to program: 00 base, 01 ext, 10 yel, 11 none
//   time_value        value to program, seconds (0 restores the default)
//   interval_address  interval to load on start (11 reads base)
//   start_timer       load and (re)start the countdown
//   expired           registered one-cycle pulse when the count reaches 0
//   busy              registered, high while counting
//   remaining         registered seconds left, for display
// -----------------------------------------------------------------------------
module interval_timer #(
   parameter int unsigned CLK_DIV  = 100_000_000,
   parameter int unsigned VAL_W    = 4,
   parameter int unsigned DEF_BASE = 6,
   parameter int unsigned DEF_EXT  = 3,
   parameter int unsigned DEF_YEL  = 2
) (
   input  logic             clk,
   input  logic             sys_reset,
   input  logic             prg_sync_in,
   input  logic [1:0]       time_param_sel,
   input  logic [VAL_W-1:0] time_value,
   input  logic [1:0]       interval_address,
   input  logic             start_timer,
   output logic             expired,
   output logic             busy,
   output logic [VAL_W-1:0] remaining
);

   localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [VAL_W-1:0] BASE_DEF = VAL_W'(DEF_BASE);
   localparam logic [VAL_W-1:0] EXT_DEF  = VAL_W'(DEF_EXT);
   localparam logic [VAL_W-1:0] YEL_DEF  = VAL_W'(DEF_YEL);

   // Shared encoding for time_param_sel and interval_address.
   typedef enum logic [1:0] {
      SEL_BASE = 2'b00,
      SEL_EXT  = 2'b01,
      SEL_YEL  = 2'b10,
      SEL_NONE = 2'b11
   } sel_e;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_e;

   // ---------------------------------------------------------------------------
   // Interval registers
   // ---------------------------------------------------------------------------
   logic [VAL_W-1:0] base_reg;
   logic [VAL_W-1:0] ext_reg;
   logic [VAL_W-1:0] yel_reg;

   // A zero interval would expire without ever counting, so a zero write
   // falls back to that register's default instead.
   // NOTE: these are three individual flops, not a memory array, so every one
   // of them gets an explicit reset value; reset never leaves them unknown.
   // NOTE: sequential state is written with <= only so every register samples
   // the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (sys_reset) begin
         base_reg <= BASE_DEF;
         ext_reg  <= EXT_DEF;
         yel_reg  <= YEL_DEF;
      end else if (prg_sync_in) begin
         case (time_param_sel)
            SEL_BASE: base_reg <= (time_value == '0) ? BASE_DEF : time_value;
            SEL_EXT:  ext_reg  <= (time_value == '0) ? EXT_DEF  : time_value;
            SEL_YEL:  yel_reg  <= (time_value == '0) ? YEL_DEF  : time_value;
            default:  ;  // SEL_NONE: nothing is written
         endcase
      end
   end

   // Read mux. This sees the register contents before any write landing on
   // the same edge, so a start concurrent with a write loads the old value.
   logic [VAL_W-1:0] load_val;

   // NOTE: every always_comb output is given a default on entry so that no
   // path through the block leaves it unassigned and infers a latch.
   always_comb begin
      load_val = base_reg;
      case (interval_address)
         SEL_EXT: load_val = ext_reg;
         SEL_YEL: load_val = yel_reg;
         default: load_val = base_reg;  // base, and 11 aliases to base
      endcase
   end

   // ---------------------------------------------------------------------------
   // Countdown FSM
   // ---------------------------------------------------------------------------
   state_e           state;
   state_e           state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_nxt;
   logic [VAL_W-1:0] rem_nxt;
   logic             exp_nxt;

   // Start has priority over the tick, so a start coinciding with the final
   // tick reloads the count and suppresses the expired pulse.
   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      rem_nxt   = remaining;
      exp_nxt   = 1'b0;

      if (start_timer) begin
         state_nxt = COUNT;
         div_nxt   = '0;
         rem_nxt   = load_val;
      end else begin
         case (state)
            IDLE: begin
               div_nxt = '0;
            end
            COUNT: begin
               if (div_cnt == DIV_LAST) begin
                  div_nxt = '0;
                  if (remaining > VAL_W'(1)) begin
                     rem_nxt = remaining - VAL_W'(1);
                  end else begin
                     // Final tick; the <= 1 test also keeps 0 from underflowing.
                     rem_nxt   = '0;
                     exp_nxt   = 1'b1;
                     state_nxt = IDLE;
                  end
               end else begin
                  div_nxt = div_cnt + DIV_W'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               div_nxt   = '0;
            end
         endcase
      end
   end

   // busy is registered from the next state so that it rises on the edge
   // after the start and falls on the same edge that expired rises.
   always_ff @(posedge clk) begin
      if (sys_reset) begin
         state     <= IDLE;
         div_cnt   <= '0;
         remaining <= '0;
         expired   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         div_cnt   <= div_nxt;
         remaining <= rem_nxt;
         expired   <= exp_nxt;
         busy      <= (state_nxt == COUNT);
      end
   end

endmodule

// File: tb/tb_interval_timer.sv
// -----------------------------------------------------------------------------
// tb_interval_timer
//
// Directed bench for interval_timer with CLK_DIV = 4. Each start pushes its
// expected expiry cycle into a scoreboard queue; a negedge monitor records the
// cycle of every observed expired pulse and the two queues are compared.
// Level checks on busy/remaining/expired are made #1 after the rising edge.
// -----------------------------------------------------------------------------
module tb_interval_timer;

   localparam int CLK_DIV = 4;
   localparam int VAL_W   = 4;

   logic             clk;
   logic             sys_reset;
   logic             prg_sync_in;
   logic [1:0]       time_param_sel;
   logic [VAL_W-1:0] time_value;
   logic [1:0]       interval_address;
   logic             start_timer;
   logic             expired;
   logic             busy;
   logic [VAL_W-1:0] remaining;

   interval_timer #(
      .CLK_DIV (CLK_DIV),
      .VAL_W   (VAL_W),
      .DEF_BASE(6),
      .DEF_EXT (3),
      .DEF_YEL (2)
   ) dut (
      .clk             (clk),
      .sys_reset       (sys_reset),
      .prg_sync_in     (prg_sync_in),
      .time_param_sel  (time_param_sel),
      .time_value      (time_value),
      .interval_address(interval_address),
      .start_timer     (start_timer),
      .expired         (expired),
      .busy            (busy),
      .remaining       (remaining)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter: after rising edge n, cyc == n.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard queues: expected expiry cycles and observed pulse cycles.
   int   exp_q[$];
   int   obs_q[$];
   int   width_err = 0;
   logic prev_exp  = 1'b0;

   always @(negedge clk) begin
      if (expired === 1'b1) begin
         obs_q.push_back(cyc);
         if (prev_exp === 1'b1) width_err <= width_err + 1;
      end
      prev_exp <= expired;
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Start is sampled on the next edge; on return cyc is that start edge E0.
   task automatic start(input logic [1:0] addr);
      interval_address = addr;
      start_timer      = 1'b1;
      tick(1);
      start_timer      = 1'b0;
   endtask

   task automatic prog(input logic [1:0] sel, input logic [VAL_W-1:0] val);
      time_param_sel = sel;
      time_value     = val;
      prg_sync_in    = 1'b1;
      tick(1);
      prg_sync_in    = 1'b0;
   endtask

   // Wait (bounded) until as many pulses were seen as expected, then compare
   // counts and cycle stamps pairwise. Queues are left empty afterwards.
   task automatic sb_compare(input string tag, input int budget);
      int waited = 0;
      while (obs_q.size() < exp_q.size() && waited < budget) begin
         tick(1);
         waited++;
      end
      check({tag, "_pulse_count"}, obs_q.size(), exp_q.size());
      while (exp_q.size() > 0 && obs_q.size() > 0)
         check({tag, "_pulse_cycle"}, obs_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      while (obs_q.size() > 0) void'(obs_q.pop_front());
   endtask

   initial begin
      int e0;
      int n;
      logic [1:0] loop_addr[4];
      int         loop_secs[4];

      sys_reset        = 1'b1;
      prg_sync_in      = 1'b0;
      time_param_sel   = 2'b00;
      time_value       = '0;
      interval_address = 2'b00;
      start_timer      = 1'b1;   // must be ignored while in reset
      tick(3);
      sys_reset   = 1'b0;
      start_timer = 1'b0;

      // --- Reset state -------------------------------------------------------
      check("rst_busy", busy, 1'b0);
      check("rst_remaining", remaining, 0);
      check("rst_expired", expired, 1'b0);
      tick(1);
      check("rst_idle_busy", busy, 1'b0);

      // --- Default base interval: 6 s -> expiry at E0+24 ---------------------
      start(2'b00);
      e0 = cyc;
      exp_q.push_back(e0 + 6 * CLK_DIV);
      check("base_load_rem", remaining, 6);
      check("base_busy_rise", busy, 1'b1);
      tick(CLK_DIV);
      check("base_first_dec", remaining, 5);
      tick(23 - CLK_DIV);
      check("base_last_busy", busy, 1'b1);
      check("base_last_rem", remaining, 1);
      check("base_last_noexp", expired, 1'b0);
      tick(1);
      check("base_exp_high", expired, 1'b1);
      check("base_busy_fall", busy, 1'b0);
      check("base_rem_zero", remaining, 0);
      tick(1);
      check("base_exp_low", expired, 1'b0);
      check("base_rem_hold", remaining, 0);
      sb_compare("base", 10);

      // --- Program ext=9, start one cycle later -> 36 cycles ----------------
      prog(2'b01, 4'd9);
      start(2'b01);
      check("ext9_load", remaining, 9);
      exp_q.push_back(cyc + 9 * CLK_DIV);
      sb_compare("ext9", 50);

      // --- Program yel with 0 -> default 2 -----------------------------------
      prog(2'b10, 4'd0);
      start(2'b10);
      check("yel0_load", remaining, 2);
      exp_q.push_back(cyc + 2 * CLK_DIV);
      sb_compare("yel0", 20);

      // --- Restart mid-count: yel at E0, base at E0+5 ------------------------
      start(2'b10);
      tick(4);
      start(2'b00);
      check("restart_load", remaining, 6);
      check("restart_busy", busy, 1'b1);
      exp_q.push_back(cyc + 6 * CLK_DIV);
      sb_compare("restart", 40);

      // --- Reset mid-count at +10 cycles -------------------------------------
      start(2'b00);
      tick(9);
      sys_reset = 1'b1;
      tick(1);
      sys_reset = 1'b0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_rem", remaining, 0);
      check("midrst_exp", expired, 1'b0);
      tick(30);
      sb_compare("midrst_quiet", 0);
      start(2'b01);
      check("midrst_ext_default", remaining, 3);
      exp_q.push_back(cyc + 3 * CLK_DIV);
      sb_compare("midrst_ext", 20);

      // --- Final tick collides with start ------------------------------------
      start(2'b10);
      tick(2 * CLK_DIV - 1);
      start(2'b01);           // sampled on the final-tick edge
      check("collide_noexp", expired, 1'b0);
      check("collide_busy", busy, 1'b1);
      check("collide_load", remaining, 3);
      exp_q.push_back(cyc + 3 * CLK_DIV);
      sb_compare("collide", 20);

      // --- sel=11 write changes nothing; addr 11 reads base ------------------
      prog(2'b11, 4'd7);
      start(2'b00);
      check("sel11_base", remaining, 6);
      start(2'b01);
      check("sel11_ext", remaining, 3);
      start(2'b10);
      check("sel11_yel", remaining, 2);
      start(2'b11);
      check("addr11_reads_base", remaining, 6);
      exp_q.push_back(cyc + 6 * CLK_DIV);
      sb_compare("addr11", 30);

      // --- Write and start in the same cycle: start loads the old value ------
      time_param_sel   = 2'b00;
      time_value       = 4'd5;
      prg_sync_in      = 1'b1;
      interval_address = 2'b00;
      start_timer      = 1'b1;
      tick(1);
      prg_sync_in      = 1'b0;
      start_timer      = 1'b0;
      check("same_cycle_old_value", remaining, 6);
      start(2'b00);
      check("same_cycle_new_value", remaining, 5);
      exp_q.push_back(cyc + 5 * CLK_DIV);
      sb_compare("base5", 30);

      // --- Controller-style loop: base, yel, base, yel, restart after pulse --
      loop_addr = '{2'b00, 2'b10, 2'b00, 2'b10};
      loop_secs = '{5, 2, 5, 2};
      for (int i = 0; i < 4; i++) begin
         start(loop_addr[i]);
         exp_q.push_back(cyc + loop_secs[i] * CLK_DIV);
         n = 0;
         while (expired !== 1'b1 && n < 40) begin
            tick(1);
            n++;
         end
         check("loop_pulse_seen", expired, 1'b1);
      end
      sb_compare("loop", 10);

      check("expired_width", width_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
